// File: rtl/burst_ctrl.sv
// Interrupter burst sequencer: turns a trig level into bounded gate-drive bursts
// (prime on gen path, run on fb lock), enforces off-time, and latches faults.
module burst_ctrl #(
   parameter int unsigned CLK_MHZ    = 100,
   parameter int unsigned ON_MAX_US  = 200,
   parameter int unsigned OFF_MIN_US = 2000,
   parameter int unsigned FB_WAIT_US = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trig,
   input  logic       lock,
   input  logic       ocd,
   input  logic       fault_clr,
   output logic       en,
   output logic       busy,
   output logic       fault,
   output logic [1:0] fault_code
);

   localparam int unsigned ON_MAX_CYC  = CLK_MHZ * ON_MAX_US;
   localparam int unsigned OFF_MIN_CYC = CLK_MHZ * OFF_MIN_US;
   localparam int unsigned FB_WAIT_CYC = CLK_MHZ * FB_WAIT_US;
   localparam int unsigned ON_W  = $clog2(ON_MAX_CYC + 1);
   localparam int unsigned OFF_W = $clog2(OFF_MIN_CYC + 1);
   localparam int unsigned FB_W  = $clog2(FB_WAIT_CYC + 1);

   localparam logic [1:0] CODE_NONE = 2'd0;
   localparam logic [1:0] CODE_OCD  = 2'd1;
   localparam logic [1:0] CODE_LOCK = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_RUN,
      S_HOLDOFF,
      S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       code_q, code_d;
   logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
   logic [FB_W-1:0]  fb_cnt_q, fb_cnt_d;
   logic [OFF_W-1:0] off_cnt_q, off_cnt_d;
   logic             trig_prev_q;

   logic [ON_W-1:0]  on_inc;
   logic [FB_W-1:0]  fb_inc;
   logic [OFF_W-1:0] off_inc;

   assign on_inc  = (on_cnt_q  == ON_W'(ON_MAX_CYC))   ? on_cnt_q  : on_cnt_q  + ON_W'(1);
   assign fb_inc  = (fb_cnt_q  == FB_W'(FB_WAIT_CYC))  ? fb_cnt_q  : fb_cnt_q  + FB_W'(1);
   assign off_inc = (off_cnt_q == OFF_W'(OFF_MIN_CYC)) ? off_cnt_q : off_cnt_q + OFF_W'(1);

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      on_cnt_d  = on_cnt_q;
      fb_cnt_d  = fb_cnt_q;
      off_cnt_d = off_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            on_cnt_d = '0;
            fb_cnt_d = '0;
            // Overcurrent beats a simultaneous trig rising edge.
            if (ocd) begin
               state_d = S_FAULT;
               code_d  = CODE_OCD;
            end else if (trig && !trig_prev_q) begin
               state_d = S_PRIME;
            end
         end
         S_PRIME, S_RUN: begin
            on_cnt_d = on_inc;
            if (state_q == S_PRIME) fb_cnt_d = fb_inc;
            if (ocd) begin
               state_d = S_FAULT;
               code_d  = CODE_OCD;
            end else if (state_q == S_PRIME && !lock && fb_cnt_q == FB_W'(FB_WAIT_CYC - 1)) begin
               state_d = S_FAULT;
               code_d  = CODE_LOCK;
            end else if (on_cnt_q == ON_W'(ON_MAX_CYC - 1) || !trig) begin
               state_d   = S_HOLDOFF;
               off_cnt_d = '0;
            end else if (state_q == S_PRIME && lock) begin
               state_d = S_RUN;
            end
         end
         S_HOLDOFF: begin
            if (ocd) begin
               state_d = S_FAULT;
               code_d  = CODE_OCD;
            end else if (off_cnt_q == OFF_W'(OFF_MIN_CYC - 1)) begin
               state_d = S_IDLE;
            end else begin
               off_cnt_d = off_inc;
            end
         end
         S_FAULT: begin
            if (fault_clr && !trig && !ocd) begin
               state_d   = S_HOLDOFF;
               code_d    = CODE_NONE;
               off_cnt_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         code_q      <= CODE_NONE;
         on_cnt_q    <= '0;
         fb_cnt_q    <= '0;
         off_cnt_q   <= '0;
         trig_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         on_cnt_q    <= on_cnt_d;
         fb_cnt_q    <= fb_cnt_d;
         off_cnt_q   <= off_cnt_d;
         trig_prev_q <= trig;
      end
   end

   assign en         = (state_q == S_PRIME) || (state_q == S_RUN);
   assign busy       = (state_q != S_IDLE);
   assign fault      = (state_q == S_FAULT);
   assign fault_code = code_q;

endmodule

// File: tb/tb_burst_ctrl.sv
// Scoreboard bench for burst_ctrl at CLK_MHZ=10: ON_MAX=50, OFF_MIN=100, FB_WAIT=20 cycles.
module tb_burst_ctrl;

   logic       clk = 1'b0;
   logic       rst, trig, lock, ocd, fault_clr;
   logic       en, busy, fault;
   logic [1:0] fault_code;

   int cmp_n = 0;
   int err_n = 0;

   typedef struct {
      string name;
      int    val;
   } item_t;

   item_t exp_q[$];
   int    act_q[$];

   always #5 clk = ~clk;

   burst_ctrl #(
      .CLK_MHZ   (10),
      .ON_MAX_US (5),
      .OFF_MIN_US(10),
      .FB_WAIT_US(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .trig      (trig),
      .lock      (lock),
      .ocd       (ocd),
      .fault_clr (fault_clr),
      .en        (en),
      .busy      (busy),
      .fault     (fault),
      .fault_code(fault_code)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string n, input int v);
      item_t it;
      it.name = n;
      it.val  = v;
      exp_q.push_back(it);
   endtask

   task automatic test_reset();
      int bc = 0;
      push("rst_en", 0); push("rst_busy", 0); push("rst_fault", 0); push("rst_code", 0);
      push("rst_held_trig_busy", 0);
      rst = 1; trig = 1; lock = 0; ocd = 0; fault_clr = 0;
      tick(); tick();
      act_q.push_back(int'(en)); act_q.push_back(int'(busy));
      act_q.push_back(int'(fault)); act_q.push_back(int'(fault_code));
      rst = 0;
      repeat (10) begin tick(); bc += int'(busy); end
      act_q.push_back(bc);
      trig = 0; tick();
      while (exp_q.size() > 0) begin
         item_t e = exp_q.pop_front();
         int a = (act_q.size() > 0) ? act_q.pop_front() : -1;
         cmp_n++;
         if (a !== e.val) begin
            $display("FAIL %s: got %0d expected %0d", e.name, a, e.val);
            err_n++;
         end
      end
      act_q.delete();
   endtask

   task automatic test_on_limit();
      int ec = 0, bc = 0;
      push("lim_en_cycles", 50); push("lim_busy_cycles", 150); push("lim_end_busy", 0);
      trig = 1;
      for (int i = 0; i < 300; i++) begin
         tick();
         ec += int'(en);
         bc += int'(busy);
         if (i == 4) lock = 1;
      end
      act_q.push_back(ec); act_q.push_back(bc); act_q.push_back(int'(busy));
      trig = 0; lock = 0; tick();
      while (exp_q.size() > 0) begin
         item_t e = exp_q.pop_front();
         int a = (act_q.size() > 0) ? act_q.pop_front() : -1;
         cmp_n++;
         if (a !== e.val) begin
            $display("FAIL %s: got %0d expected %0d", e.name, a, e.val);
            err_n++;
         end
      end
      act_q.delete();
   endtask

   task automatic test_early_release();
      int ec = 0, hc = 0, rc = 0;
      push("rel_en_cycles", 30); push("rel_en_after", 0); push("rel_busy_after", 1);
      push("rel_hold_cycles", 100); push("rel_rerise_en", 0);
      trig = 1; lock = 1;
      repeat (30) begin tick(); ec += int'(en); end
      act_q.push_back(ec);
      trig = 0; tick();
      act_q.push_back(int'(en)); act_q.push_back(int'(busy));
      hc = int'(busy);
      for (int i = 0; i < 200; i++) begin
         if (i == 40) trig = 1;
         tick();
         hc += int'(busy);
         rc += int'(en);
      end
      act_q.push_back(hc); act_q.push_back(rc);
      trig = 0; lock = 0; tick();
      while (exp_q.size() > 0) begin
         item_t e = exp_q.pop_front();
         int a = (act_q.size() > 0) ? act_q.pop_front() : -1;
         cmp_n++;
         if (a !== e.val) begin
            $display("FAIL %s: got %0d expected %0d", e.name, a, e.val);
            err_n++;
         end
      end
      act_q.delete();
   endtask

   task automatic test_lock_timeout();
      int ec = 0, hc = 0;
      push("lto_en_cycles", 20); push("lto_fault", 1); push("lto_code", 2); push("lto_en_final", 0);
      push("lto_clr_fault", 0); push("lto_clr_code", 0); push("lto_hold_cycles", 100);
      trig = 1; lock = 0;
      repeat (30) begin tick(); ec += int'(en); end
      act_q.push_back(ec); act_q.push_back(int'(fault));
      act_q.push_back(int'(fault_code)); act_q.push_back(int'(en));
      trig = 0; fault_clr = 1; tick(); fault_clr = 0;
      act_q.push_back(int'(fault)); act_q.push_back(int'(fault_code));
      hc = int'(busy);
      repeat (200) begin tick(); hc += int'(busy); end
      act_q.push_back(hc);
      while (exp_q.size() > 0) begin
         item_t e = exp_q.pop_front();
         int a = (act_q.size() > 0) ? act_q.pop_front() : -1;
         cmp_n++;
         if (a !== e.val) begin
            $display("FAIL %s: got %0d expected %0d", e.name, a, e.val);
            err_n++;
         end
      end
      act_q.delete();
   endtask

   task automatic test_ocd();
      int hc = 0;
      push("ocd_en", 0); push("ocd_fault", 1); push("ocd_code", 1);
      push("ocd_clr_trig_fault", 1); push("ocd_clr_trig_code", 1);
      push("ocd_clr_fault", 0); push("ocd_clr_code", 0);
      push("ocd_hold_cycles", 100); push("ocd_end_code", 0);
      trig = 1; lock = 1;
      repeat (10) tick();
      ocd = 1; tick(); ocd = 0;
      act_q.push_back(int'(en)); act_q.push_back(int'(fault)); act_q.push_back(int'(fault_code));
      fault_clr = 1; tick();
      act_q.push_back(int'(fault)); act_q.push_back(int'(fault_code));
      trig = 0; lock = 0; tick(); fault_clr = 0;
      act_q.push_back(int'(fault)); act_q.push_back(int'(fault_code));
      hc = int'(busy);
      repeat (200) begin tick(); hc += int'(busy); end
      act_q.push_back(hc); act_q.push_back(int'(fault_code));
      while (exp_q.size() > 0) begin
         item_t e = exp_q.pop_front();
         int a = (act_q.size() > 0) ? act_q.pop_front() : -1;
         cmp_n++;
         if (a !== e.val) begin
            $display("FAIL %s: got %0d expected %0d", e.name, a, e.val);
            err_n++;
         end
      end
      act_q.delete();
   endtask

   task automatic test_simultaneous();
      int ec = 0;
      push("sim_fault", 1); push("sim_code", 1); push("sim_en_cycles", 0);
      trig = 0; tick();
      trig = 1; ocd = 1; tick();
      ec += int'(en);
      act_q.push_back(int'(fault)); act_q.push_back(int'(fault_code));
      ocd = 0;
      repeat (5) begin tick(); ec += int'(en); end
      act_q.push_back(ec);
      trig = 0; fault_clr = 1; tick(); fault_clr = 0;
      repeat (110) tick();
      while (exp_q.size() > 0) begin
         item_t e = exp_q.pop_front();
         int a = (act_q.size() > 0) ? act_q.pop_front() : -1;
         cmp_n++;
         if (a !== e.val) begin
            $display("FAIL %s: got %0d expected %0d", e.name, a, e.val);
            err_n++;
         end
      end
      act_q.delete();
   endtask

   task automatic test_reset_mid_run();
      int bc = 0;
      push("rmr_en", 0); push("rmr_busy", 0); push("rmr_fault", 0);
      push("rmr_busy_held", 0); push("rmr_new_en", 1);
      trig = 1; lock = 1;
      repeat (10) tick();
      rst = 1; tick();
      act_q.push_back(int'(en)); act_q.push_back(int'(busy)); act_q.push_back(int'(fault));
      rst = 0;
      repeat (20) begin tick(); bc += int'(busy); end
      act_q.push_back(bc);
      trig = 0; tick();
      trig = 1; tick();
      act_q.push_back(int'(en));
      trig = 0; lock = 0; tick();
      repeat (110) tick();
      while (exp_q.size() > 0) begin
         item_t e = exp_q.pop_front();
         int a = (act_q.size() > 0) ? act_q.pop_front() : -1;
         cmp_n++;
         if (a !== e.val) begin
            $display("FAIL %s: got %0d expected %0d", e.name, a, e.val);
            err_n++;
         end
      end
      act_q.delete();
   endtask

   initial begin
      test_reset();
      test_on_limit();
      test_early_release();
      test_lock_timeout();
      test_ocd();
      test_simultaneous();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
